// File: rtl/fft_stage_ctrl.sv
// Stage/butterfly sequencer for an in-place radix-2 DIT FFT.
// Emits operand-pair addresses and twiddle index per butterfly, with a drain gap between stages.
module fft_stage_ctrl #(
  parameter int N        = 8,
  parameter int LOG2N    = 3,
  parameter int PIPE_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stall,
  output logic             busy,
  output logic             valid,
  output logic             done,
  output logic [LOG2N-1:0] stage,
  output logic [LOG2N-1:0] addr_a,
  output logic [LOG2N-1:0] addr_b,
  output logic [LOG2N-2:0] tw_addr
);

  localparam int JW = LOG2N - 1;
  localparam int DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [JW-1:0]    J_LAST = JW'(N / 2 - 1);
  localparam logic [LOG2N-1:0] S_LAST = LOG2N'(LOG2N - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_reg, state_next;
  logic [LOG2N-1:0] s_reg, s_next;
  logic [JW-1:0]    j_reg, j_next;
  logic [DW-1:0]    dcnt_reg, dcnt_next;
  logic             busy_reg, busy_next;
  logic             valid_reg, valid_next;
  logic             done_reg, done_next;
  logic             load_next;
  logic [LOG2N-1:0] addr_a_reg, addr_b_reg;
  logic [LOG2N-2:0] tw_addr_reg;
  logic [3*LOG2N-2:0] bfly_next;

  // Butterfly geometry for stage s, butterfly j: {addr_a, addr_b, tw_addr}.
  function automatic logic [3*LOG2N-2:0] bfly(input logic [LOG2N-1:0] s,
                                               input logic [JW-1:0] j);
    logic [LOG2N-1:0] jx, span, pos, grp, a, twf;
    jx   = {1'b0, j};
    span = LOG2N'(1) << s;
    pos  = jx & (span - LOG2N'(1));
    grp  = jx >> s;
    a    = (grp << (s + LOG2N'(1))) | pos;
    twf  = pos << (S_LAST - s);
    return {a, a + span, twf[LOG2N-2:0]};
  endfunction

  // Each non-stalled edge advances one slot (beat, drain cycle or done).
  // A stalled edge repeats the current slot with valid low, so a beat shown
  // once with valid high is never re-issued.
  always_comb begin
    state_next = state_reg;
    s_next     = s_reg;
    j_next     = j_reg;
    dcnt_next  = dcnt_reg;
    busy_next  = 1'b0;
    valid_next = 1'b0;
    done_next  = 1'b0;
    load_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = RUN;
          s_next     = '0;
          j_next     = '0;
          busy_next  = 1'b1;
          valid_next = 1'b1;
          load_next  = 1'b1;
        end
      end
      RUN: begin
        busy_next = 1'b1;
        if (!stall) begin
          if (j_reg != J_LAST) begin
            j_next     = j_reg + JW'(1);
            valid_next = 1'b1;
            load_next  = 1'b1;
          end else if (PIPE_LAT > 0) begin
            state_next = DRAIN;
            dcnt_next  = '0;
          end else if (s_reg != S_LAST) begin
            s_next     = s_reg + LOG2N'(1);
            j_next     = '0;
            valid_next = 1'b1;
            load_next  = 1'b1;
          end else begin
            state_next = DONE;
            busy_next  = 1'b0;
            done_next  = 1'b1;
          end
        end
      end
      DRAIN: begin
        busy_next = 1'b1;
        if (!stall) begin
          if (int'(dcnt_reg) == PIPE_LAT - 1) begin
            if (s_reg != S_LAST) begin
              state_next = RUN;
              s_next     = s_reg + LOG2N'(1);
              j_next     = '0;
              valid_next = 1'b1;
              load_next  = 1'b1;
            end else begin
              state_next = DONE;
              busy_next  = 1'b0;
              done_next  = 1'b1;
            end
          end else begin
            dcnt_next = dcnt_reg + DW'(1);
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bfly_next = bfly(s_next, j_next);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      s_reg       <= '0;
      j_reg       <= '0;
      dcnt_reg    <= '0;
      busy_reg    <= 1'b0;
      valid_reg   <= 1'b0;
      done_reg    <= 1'b0;
      addr_a_reg  <= '0;
      addr_b_reg  <= '0;
      tw_addr_reg <= '0;
    end else begin
      state_reg <= state_next;
      s_reg     <= s_next;
      j_reg     <= j_next;
      dcnt_reg  <= dcnt_next;
      busy_reg  <= busy_next;
      valid_reg <= valid_next;
      done_reg  <= done_next;
      if (load_next) begin
        {addr_a_reg, addr_b_reg, tw_addr_reg} <= bfly_next;
      end
    end
  end

  assign busy    = busy_reg;
  assign valid   = valid_reg;
  assign done    = done_reg;
  assign stage   = s_reg;
  assign addr_a  = addr_a_reg;
  assign addr_b  = addr_b_reg;
  assign tw_addr = tw_addr_reg;

endmodule

// File: tb/tb_fft_stage_ctrl.sv
// Scoreboard bench for fft_stage_ctrl: N=8/PIPE_LAT=2 and N=16/PIPE_LAT=0 instances.
module tb_fft_stage_ctrl;

  logic clk;
  logic rst;
  logic start8, stall8, start16, stall16;
  logic busy8, valid8, done8;
  logic [2:0] stage8, addr_a8, addr_b8;
  logic [1:0] tw8;
  logic busy16, valid16, done16;
  logic [3:0] stage16, addr_a16, addr_b16;
  logic [2:0] tw16;

  // Beat encoding: {stage, addr_a, addr_b, tw_addr}, one nibble each.
  typedef logic [15:0] beat_t;
  typedef struct packed {
    logic [15:0] busy;
    logic [15:0] valid;
  } run_t;

  localparam beat_t EXP8 [12] = '{
    16'h0010, 16'h0230, 16'h0450, 16'h0670,
    16'h1020, 16'h1132, 16'h1460, 16'h1572,
    16'h2040, 16'h2151, 16'h2262, 16'h2373
  };
  localparam beat_t EXP16 [32] = '{
    16'h0010, 16'h0230, 16'h0450, 16'h0670, 16'h0890, 16'h0AB0, 16'h0CD0, 16'h0EF0,
    16'h1020, 16'h1134, 16'h1460, 16'h1574, 16'h18A0, 16'h19B4, 16'h1CE0, 16'h1DF4,
    16'h2040, 16'h2152, 16'h2264, 16'h2376, 16'h28C0, 16'h29D2, 16'h2AE4, 16'h2BF6,
    16'h3080, 16'h3191, 16'h32A2, 16'h33B3, 16'h34C4, 16'h35D5, 16'h36E6, 16'h37F7
  };

  beat_t q8[$];
  beat_t q16[$];
  run_t  r8[$];
  run_t  r16[$];

  int    checks;
  int    errors;
  logic  end_req;

  fft_stage_ctrl #(.N(8), .LOG2N(3), .PIPE_LAT(2)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .stall(stall8),
    .busy(busy8), .valid(valid8), .done(done8), .stage(stage8),
    .addr_a(addr_a8), .addr_b(addr_b8), .tw_addr(tw8)
  );

  fft_stage_ctrl #(.N(16), .LOG2N(4), .PIPE_LAT(0)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .stall(stall16),
    .busy(busy16), .valid(valid16), .done(done16), .stage(stage16),
    .addr_a(addr_a16), .addr_b(addr_b16), .tw_addr(tw16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic start_run8(input int busy_cycles);
    run_t r;
    for (int i = 0; i < 12; i++) q8.push_back(EXP8[i]);
    r.busy  = 16'(busy_cycles);
    r.valid = 16'd12;
    r8.push_back(r);
    start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Stimulus: every input change happens 1 time unit after a rising edge.
  initial begin
    run_t r;
    rst = 1'b1; start8 = 1'b0; stall8 = 1'b0; start16 = 1'b0; stall16 = 1'b0;
    end_req = 1'b0;
    wait_cycles(3);
    rst = 1'b0;
    wait_cycles(2);

    // Plain run: 18 busy, 12 beats, one done.
    start_run8(18);
    wait_cycles(25);

    // Stall 3 cycles after beat (1,3,2) is shown, and 1 cycle in the first drain of stage1.
    start_run8(22);
    wait_cycles(7);
    stall8 = 1'b1;
    wait_cycles(3);
    stall8 = 1'b0;
    wait_cycles(3);
    stall8 = 1'b1;
    wait_cycles(1);
    stall8 = 1'b0;
    wait_cycles(30);

    // Reset during stage1, then a full clean run.
    start_run8(18);
    wait_cycles(7);
    rst = 1'b1;
    wait_cycles(1);
    rst = 1'b0;
    wait_cycles(2);
    start_run8(18);
    wait_cycles(25);

    // start pulses during RUN/DRAIN and in the DONE cycle are ignored.
    start_run8(18);
    wait_cycles(4);
    start8 = 1'b1;
    wait_cycles(1);
    start8 = 1'b0;
    wait_cycles(13);
    start8 = 1'b1;
    wait_cycles(1);
    start8 = 1'b0;
    wait_cycles(30);

    // N=16, no drain gap: 32 back-to-back beats.
    for (int i = 0; i < 32; i++) q16.push_back(EXP16[i]);
    r.busy  = 16'd32;
    r.valid = 16'd32;
    r16.push_back(r);
    start16 = 1'b1;
    wait_cycles(1);
    start16 = 1'b0;
    wait_cycles(40);

    end_req = 1'b1;
    wait_cycles(5);
  end

  // Monitor: samples on the falling edge, pops expectations when the DUT presents them.
  initial begin
    beat_t obs8, obs16, e, last8;
    run_t  rr;
    logic  rst_seen, stall_seen8, prev_valid8, prev_done8, prev_valid16, prev_done16;
    int    busy_run8, valid_run8, busy_run16, valid_run16;
    checks = 0; errors = 0;
    rst_seen = 1'b0; stall_seen8 = 1'b0; prev_valid8 = 1'b0; prev_done8 = 1'b0;
    prev_valid16 = 1'b0; prev_done16 = 1'b0; last8 = '0;
    busy_run8 = 0; valid_run8 = 0; busy_run16 = 0; valid_run16 = 0;
    forever begin
      @(negedge clk);
      obs8  = {1'b0, stage8, 1'b0, addr_a8, 1'b0, addr_b8, 2'b00, tw8};
      obs16 = {stage16, addr_a16, addr_b16, 1'b0, tw16};
      if (rst_seen) begin
        checks++;
        if ({busy8, valid8, done8, obs8} != '0) begin
          errors++;
          $display("FAIL reset8: got busy=%0b valid=%0b done=%0b beat=%h, want all 0",
                   busy8, valid8, done8, obs8);
        end
        checks++;
        if ({busy16, valid16, done16, obs16} != '0) begin
          errors++;
          $display("FAIL reset16: got busy=%0b valid=%0b done=%0b beat=%h, want all 0",
                   busy16, valid16, done16, obs16);
        end
        q8.delete(); r8.delete(); q16.delete(); r16.delete();
        busy_run8 = 0; valid_run8 = 0; busy_run16 = 0; valid_run16 = 0;
        last8 = '0;
      end else begin
        if (stall_seen8 && busy8) begin
          checks++;
          if (valid8) begin
            errors++;
            $display("FAIL stall_valid8: got valid=1, want 0");
          end
        end
        if (stall_seen8 && prev_valid8) begin
          checks++;
          if (obs8 != last8) begin
            errors++;
            $display("FAIL stall_hold8: got beat=%h, want %h", obs8, last8);
          end
        end
        if (valid8) begin
          checks++;
          if (q8.size() == 0) begin
            errors++;
            $display("FAIL beat8: got unexpected beat=%h, want none", obs8);
          end else begin
            e = q8.pop_front();
            last8 = e;
            if (obs8 != e) begin
              errors++;
              $display("FAIL beat8: got %h, want %h", obs8, e);
            end
          end
        end
        if (busy8) busy_run8++;
        if (valid8) valid_run8++;
        if (done8) begin
          checks++;
          if (prev_done8 || busy8 || valid8) begin
            errors++;
            $display("FAIL done_shape8: got prev_done=%0b busy=%0b valid=%0b, want 0 0 0",
                     prev_done8, busy8, valid8);
          end
          checks++;
          if (r8.size() == 0) begin
            errors++;
            $display("FAIL done8: got unexpected done pulse, want none");
          end else begin
            rr = r8.pop_front();
            if (busy_run8 != int'(rr.busy) || valid_run8 != int'(rr.valid)) begin
              errors++;
              $display("FAIL run8: got busy=%0d valid=%0d, want busy=%0d valid=%0d",
                       busy_run8, valid_run8, rr.busy, rr.valid);
            end
          end
          busy_run8 = 0; valid_run8 = 0;
        end

        if (busy16) begin
          checks++;
          if (!valid16) begin
            errors++;
            $display("FAIL gap16: got valid=0 while busy, want 1");
          end
        end
        if (valid16) begin
          checks++;
          if (q16.size() == 0) begin
            errors++;
            $display("FAIL beat16: got unexpected beat=%h, want none", obs16);
          end else begin
            e = q16.pop_front();
            if (obs16 != e) begin
              errors++;
              $display("FAIL beat16: got %h, want %h", obs16, e);
            end
          end
        end
        if (busy16) busy_run16++;
        if (valid16) valid_run16++;
        if (done16) begin
          checks++;
          if (prev_done16 || busy16 || !prev_valid16) begin
            errors++;
            $display("FAIL done_shape16: got prev_done=%0b busy=%0b prev_valid=%0b, want 0 0 1",
                     prev_done16, busy16, prev_valid16);
          end
          checks++;
          if (r16.size() == 0) begin
            errors++;
            $display("FAIL done16: got unexpected done pulse, want none");
          end else begin
            rr = r16.pop_front();
            if (busy_run16 != int'(rr.busy) || valid_run16 != int'(rr.valid)) begin
              errors++;
              $display("FAIL run16: got busy=%0d valid=%0d, want busy=%0d valid=%0d",
                       busy_run16, valid_run16, rr.busy, rr.valid);
            end
          end
          busy_run16 = 0; valid_run16 = 0;
        end
      end
      rst_seen     = rst;
      stall_seen8  = stall8;
      prev_valid8  = valid8;
      prev_done8   = done8;
      prev_valid16 = valid16;
      prev_done16  = done16;
      if (end_req) begin
        checks++;
        if (q8.size() != 0 || r8.size() != 0) begin
          errors++;
          $display("FAIL drain8: got %0d beats %0d runs pending, want 0 0", q8.size(), r8.size());
        end
        checks++;
        if (q16.size() != 0 || r16.size() != 0) begin
          errors++;
          $display("FAIL drain16: got %0d beats %0d runs pending, want 0 0",
                   q16.size(), r16.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
      end
    end
  end

endmodule
